// File: rtl/tlb_param.sv
// Parametrised fully associative MIPS32 joint TLB with I/D translation, TLBP probe and TLBR read ports.
// Optional feature macro: TLB_RANDOM_EN enables the CP0 Random counter and TLBWR random-index writes.
module tlb_param #(
    parameter int TLBNUM = 16,
    parameter int ASID_W = 8,
    localparam int IDX_W = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ASID_W-1:0] cur_asid,
    input  logic              i_req,
    input  logic [19:0]       i_vpn,
    output logic              i_valid,
    output logic              i_hit,
    output logic [24:0]       i_lo,
    input  logic              d_req,
    input  logic [19:0]       d_vpn,
    output logic              d_valid,
    output logic              d_hit,
    output logic [24:0]       d_lo,
    input  logic              we,
    input  logic              wr_random,
    input  logic [IDX_W-1:0]  w_index,
    input  logic [18:0]       w_vpn2,
    input  logic [ASID_W-1:0] w_asid,
    input  logic              w_g,
    input  logic [24:0]       w_lo0,
    input  logic [24:0]       w_lo1,
    input  logic              r_req,
    input  logic [IDX_W-1:0]  r_index,
    output logic              r_valid,
    output logic [18:0]       r_vpn2,
    output logic [ASID_W-1:0] r_asid,
    output logic              r_g,
    output logic [24:0]       r_lo0,
    output logic [24:0]       r_lo1,
    input  logic              p_req,
    input  logic [18:0]       p_vpn2,
    input  logic [ASID_W-1:0] p_asid,
    output logic              p_valid,
    output logic              p_miss,
    output logic [IDX_W-1:0]  p_index,
    input  logic [IDX_W-1:0]  wired,
    output logic [IDX_W-1:0]  random_index
);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLBNUM - 1);

    logic [18:0]       vpn2_q [TLBNUM];
    logic [ASID_W-1:0] asid_q [TLBNUM];
    logic              g_q    [TLBNUM];
    logic [24:0]       lo0_q  [TLBNUM];
    logic [24:0]       lo1_q  [TLBNUM];

    logic              i_valid_q, i_hit_q, d_valid_q, d_hit_q;
    logic [24:0]       i_lo_q, d_lo_q, r_lo0_q, r_lo1_q;
    logic              r_valid_q, r_g_q, p_valid_q, p_miss_q;
    logic [18:0]       r_vpn2_q;
    logic [ASID_W-1:0] r_asid_q;
    logic [IDX_W-1:0]  p_index_q, rand_q, w_idx_s;

    logic [TLBNUM-1:0] i_m_s, d_m_s, p_m_s;
    logic [IDX_W:0]    i_sel_s, d_sel_s, p_sel_s;
    logic [24:0]       i_lo_d, d_lo_d;

    // Returns {found, index}; the lowest matching index takes priority.
    function automatic logic [IDX_W:0] first_idx(input logic [TLBNUM-1:0] m);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, IDX_W'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Per-entry match vectors for the three associative ports.
    always_comb begin
        i_m_s = '0;
        d_m_s = '0;
        p_m_s = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            i_m_s[i] = (vpn2_q[i] == i_vpn[19:1]) && (g_q[i] || (asid_q[i] == cur_asid));
            d_m_s[i] = (vpn2_q[i] == d_vpn[19:1]) && (g_q[i] || (asid_q[i] == cur_asid));
            p_m_s[i] = (vpn2_q[i] == p_vpn2) && (g_q[i] || (asid_q[i] == p_asid));
        end
    end

    assign i_sel_s = first_idx(i_m_s);
    assign d_sel_s = first_idx(d_m_s);
    assign p_sel_s = first_idx(p_m_s);

    // Odd/even page selection by vaddr[12]; a miss yields an all-zero EntryLo.
    always_comb begin
        i_lo_d = 25'd0;
        d_lo_d = 25'd0;
        if (i_sel_s[IDX_W]) begin
            i_lo_d = i_vpn[0] ? lo1_q[i_sel_s[IDX_W-1:0]] : lo0_q[i_sel_s[IDX_W-1:0]];
        end else begin
            i_lo_d = 25'd0;
        end
        if (d_sel_s[IDX_W]) begin
            d_lo_d = d_vpn[0] ? lo1_q[d_sel_s[IDX_W-1:0]] : lo0_q[d_sel_s[IDX_W-1:0]];
        end else begin
            d_lo_d = 25'd0;
        end
    end

`ifdef TLB_RANDOM_EN
    logic [IDX_W-1:0] rand_d;

    // Random wraps back to the top once it reaches the wired boundary or zero.
    always_comb begin
        if ((rand_q <= wired) || (rand_q == '0)) begin
            rand_d = IDX_MAX;
        end else begin
            rand_d = rand_q - IDX_W'(1);
        end
        if (wr_random) begin
            w_idx_s = rand_q;
        end else begin
            w_idx_s = w_index;
        end
    end

    // Random counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rand_q <= IDX_MAX;
        end else begin
            rand_q <= rand_d;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{wired, wr_random, IDX_MAX};
    assign rand_q  = '0;
    assign w_idx_s = w_index;
`endif

    // Entry array and registered port results; data holds while its request is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLBNUM; i++) begin
                vpn2_q[i] <= 19'd0;
                asid_q[i] <= '0;
                g_q[i]    <= 1'b0;
                lo0_q[i]  <= 25'd0;
                lo1_q[i]  <= 25'd0;
            end
            i_valid_q <= 1'b0; i_hit_q <= 1'b0; i_lo_q <= 25'd0;
            d_valid_q <= 1'b0; d_hit_q <= 1'b0; d_lo_q <= 25'd0;
            r_valid_q <= 1'b0; r_vpn2_q <= 19'd0; r_asid_q <= '0;
            r_g_q     <= 1'b0; r_lo0_q <= 25'd0; r_lo1_q <= 25'd0;
            p_valid_q <= 1'b0; p_miss_q <= 1'b0; p_index_q <= '0;
        end else begin
            if (we) begin
                vpn2_q[w_idx_s] <= w_vpn2;
                asid_q[w_idx_s] <= w_asid;
                g_q[w_idx_s]    <= w_g;
                lo0_q[w_idx_s]  <= w_lo0;
                lo1_q[w_idx_s]  <= w_lo1;
            end
            i_valid_q <= i_req;
            d_valid_q <= d_req;
            r_valid_q <= r_req;
            p_valid_q <= p_req;
            if (i_req) begin
                i_hit_q <= i_sel_s[IDX_W];
                i_lo_q  <= i_lo_d;
            end
            if (d_req) begin
                d_hit_q <= d_sel_s[IDX_W];
                d_lo_q  <= d_lo_d;
            end
            if (r_req) begin
                r_vpn2_q <= vpn2_q[r_index];
                r_asid_q <= asid_q[r_index];
                r_g_q    <= g_q[r_index];
                r_lo0_q  <= lo0_q[r_index];
                r_lo1_q  <= lo1_q[r_index];
            end
            if (p_req) begin
                p_miss_q  <= ~p_sel_s[IDX_W];
                p_index_q <= p_sel_s[IDX_W-1:0];
            end
        end
    end

    assign i_valid = i_valid_q;  assign i_hit = i_hit_q;  assign i_lo = i_lo_q;
    assign d_valid = d_valid_q;  assign d_hit = d_hit_q;  assign d_lo = d_lo_q;
    assign r_valid = r_valid_q;  assign r_vpn2 = r_vpn2_q; assign r_asid = r_asid_q;
    assign r_g = r_g_q;          assign r_lo0 = r_lo0_q;  assign r_lo1 = r_lo1_q;
    assign p_valid = p_valid_q;  assign p_miss = p_miss_q; assign p_index = p_index_q;
    assign random_index = rand_q;
endmodule

// File: tb/tb_tlb_param.sv
// Self-checking bench for tlb_param: directed scenarios plus randomized traffic against an entry-table model.
module tb_tlb_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cur_asid;
    logic        i_req, d_req, we, wr_random, r_req, p_req, w_g;
    logic [19:0] i_vpn, d_vpn;
    logic        i_valid, i_hit, d_valid, d_hit, r_valid, r_g, p_valid, p_miss;
    logic [24:0] i_lo, d_lo, w_lo0, w_lo1, r_lo0, r_lo1;
    logic [3:0]  w_index, r_index, p_index, wired, random_index;
    logic [18:0] w_vpn2, r_vpn2, p_vpn2;
    logic [7:0]  w_asid, r_asid, p_asid;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];
    logic        m_g    [16];
    logic [24:0] m_lo0  [16];
    logic [24:0] m_lo1  [16];
    logic [3:0]  m_rnd;

    logic        e_i_valid, e_i_hit, e_d_valid, e_d_hit, e_r_valid, e_r_g, e_p_valid, e_p_miss;
    logic [24:0] e_i_lo, e_d_lo, e_r_lo0, e_r_lo1;
    logic [18:0] e_r_vpn2;
    logic [7:0]  e_r_asid;
    logic [3:0]  e_p_index;

    always #5 clk = ~clk;

    tlb_param #(.TLBNUM(16), .ASID_W(8)) dut (
        .clk(clk), .rst(rst), .cur_asid(cur_asid),
        .i_req(i_req), .i_vpn(i_vpn), .i_valid(i_valid), .i_hit(i_hit), .i_lo(i_lo),
        .d_req(d_req), .d_vpn(d_vpn), .d_valid(d_valid), .d_hit(d_hit), .d_lo(d_lo),
        .we(we), .wr_random(wr_random), .w_index(w_index), .w_vpn2(w_vpn2),
        .w_asid(w_asid), .w_g(w_g), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_vpn2(r_vpn2),
        .r_asid(r_asid), .r_g(r_g), .r_lo0(r_lo0), .r_lo1(r_lo1),
        .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid), .p_valid(p_valid),
        .p_miss(p_miss), .p_index(p_index), .wired(wired), .random_index(random_index)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] reset_rnd();
`ifdef TLB_RANDOM_EN
        return 4'd15;
`else
        return 4'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_vpn2[i] = 19'd0; m_asid[i] = 8'd0; m_g[i] = 1'b0;
            m_lo0[i] = 25'd0;  m_lo1[i] = 25'd0;
        end
        m_rnd = reset_rnd();
        e_i_valid = 1'b0; e_i_hit = 1'b0; e_i_lo = 25'd0;
        e_d_valid = 1'b0; e_d_hit = 1'b0; e_d_lo = 25'd0;
        e_r_valid = 1'b0; e_r_vpn2 = 19'd0; e_r_asid = 8'd0; e_r_g = 1'b0;
        e_r_lo0 = 25'd0;  e_r_lo1 = 25'd0;
        e_p_valid = 1'b0; e_p_miss = 1'b0; e_p_index = 4'd0;
    endtask

    // Lowest-numbered matching entry, or -1.
    function automatic int find(input logic [18:0] v, input logic [7:0] a);
        for (int i = 0; i < 16; i++) begin
            if (m_vpn2[i] == v && (m_g[i] || m_asid[i] == a)) return i;
        end
        return -1;
    endfunction

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; r_req = 1'b0; p_req = 1'b0;
        we = 1'b0; wr_random = 1'b0;
    endtask

    task automatic check_all();
        check("i_valid", i_valid, e_i_valid); check("i_hit", i_hit, e_i_hit);
        check("i_lo", i_lo, e_i_lo);
        check("d_valid", d_valid, e_d_valid); check("d_hit", d_hit, e_d_hit);
        check("d_lo", d_lo, e_d_lo);
        check("r_valid", r_valid, e_r_valid); check("r_vpn2", r_vpn2, e_r_vpn2);
        check("r_asid", r_asid, e_r_asid); check("r_g", r_g, e_r_g);
        check("r_lo0", r_lo0, e_r_lo0); check("r_lo1", r_lo1, e_r_lo1);
        check("p_valid", p_valid, e_p_valid); check("p_miss", p_miss, e_p_miss);
        check("p_index", p_index, e_p_index);
        check("random_index", random_index, m_rnd);
    endtask

    // One clock: predict from pre-edge table, then apply the write and Random step.
    task automatic do_cycle();
        int idx;
        logic [3:0] widx;
        e_i_valid = i_req;
        if (i_req) begin
            idx = find(i_vpn[19:1], cur_asid);
            e_i_hit = (idx >= 0);
            if (idx >= 0) e_i_lo = i_vpn[0] ? m_lo1[idx] : m_lo0[idx];
            else e_i_lo = 25'd0;
        end
        e_d_valid = d_req;
        if (d_req) begin
            idx = find(d_vpn[19:1], cur_asid);
            e_d_hit = (idx >= 0);
            if (idx >= 0) e_d_lo = d_vpn[0] ? m_lo1[idx] : m_lo0[idx];
            else e_d_lo = 25'd0;
        end
        e_p_valid = p_req;
        if (p_req) begin
            idx = find(p_vpn2, p_asid);
            e_p_miss = (idx < 0);
            e_p_index = (idx < 0) ? 4'd0 : 4'(idx);
        end
        e_r_valid = r_req;
        if (r_req) begin
            e_r_vpn2 = m_vpn2[r_index]; e_r_asid = m_asid[r_index]; e_r_g = m_g[r_index];
            e_r_lo0 = m_lo0[r_index];   e_r_lo1 = m_lo1[r_index];
        end
        widx = w_index;
`ifdef TLB_RANDOM_EN
        if (wr_random) widx = m_rnd;
`endif
        @(posedge clk);
        #1;
        if (we) begin
            m_vpn2[widx] = w_vpn2; m_asid[widx] = w_asid; m_g[widx] = w_g;
            m_lo0[widx] = w_lo0;   m_lo1[widx] = w_lo1;
        end
`ifdef TLB_RANDOM_EN
        if (m_rnd <= wired || m_rnd == 4'd0) m_rnd = 4'd15;
        else m_rnd = m_rnd - 4'd1;
`endif
        check_all();
    endtask

    task automatic set_write(input logic [3:0] idx, input logic [18:0] v, input logic [7:0] a,
                             input logic g, input logic [24:0] l0, input logic [24:0] l1);
        we = 1'b1; w_index = idx; w_vpn2 = v; w_asid = a; w_g = g; w_lo0 = l0; w_lo1 = l1;
    endtask

    initial begin
        rst = 1'b0; cur_asid = 8'd0; i_vpn = 20'd0; d_vpn = 20'd0;
        w_index = 4'd0; w_vpn2 = 19'd0; w_asid = 8'd0; w_g = 1'b0;
        w_lo0 = 25'd0; w_lo1 = 25'd0; r_index = 4'd0; p_vpn2 = 19'd0; p_asid = 8'd0;
        wired = 4'd0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Empty TLB misses.
        i_req = 1'b1; i_vpn = 20'h00400;
        do_cycle();
        check("t1_lo_zero", i_lo, 25'd0);
        idle();

        // ASID-qualified entry 3, odd page selected by vaddr[12].
        set_write(4'd3, 19'h00200, 8'd5, 1'b0, {20'h01234, 3'd3, 1'b1, 1'b1},
                  {20'h05678, 3'd2, 1'b0, 1'b1});
        do_cycle();
        idle();
        cur_asid = 8'd5; d_req = 1'b1; d_vpn = 20'h00401;
        do_cycle();
        check("t2_hit", d_hit, 1'b1);
        check("t2_pfn", d_lo[24:5], 20'h05678);
        check("t2_dv", d_lo[1:0], 2'b01);
        cur_asid = 8'd6;
        do_cycle();
        check("t2_asid_miss", d_hit, 1'b0);
        idle();

        // Duplicate global matches resolve to the lowest index.
        set_write(4'd9, 19'h00007, 8'd1, 1'b1, 25'h0aaaaaa, 25'h0555555);
        do_cycle();
        set_write(4'd2, 19'h00007, 8'd2, 1'b1, 25'h1111111, 25'h0222222);
        do_cycle();
        idle();
        p_req = 1'b1; p_vpn2 = 19'h00007; p_asid = 8'd77;
        do_cycle();
        check("t3_pidx", p_index, 4'd2);
        check("t3_pmiss", p_miss, 1'b0);
        p_vpn2 = 19'h00008;
        do_cycle();
        check("t3_unmatched", {p_miss, p_index}, {1'b1, 4'd0});
        idle();

        // Read in the same cycle as a write sees the old contents.
        set_write(4'd4, 19'h0abcd, 8'd9, 1'b0, 25'h0123456, 25'h0654321);
        r_req = 1'b1; r_index = 4'd4;
        do_cycle();
        check("t4_old", r_vpn2, 19'd0);
        we = 1'b0;
        do_cycle();
        check("t4_new", r_vpn2, 19'h0abcd);
        idle();

        // Random counter with wired=12, and a TLBWR while Random is 14.
        wired = 4'd12;
        repeat (6) do_cycle();
`ifdef TLB_RANDOM_EN
        for (int k = 0; k < 40 && m_rnd != 4'd14; k++) do_cycle();
        check("t5_rnd14", random_index, 4'd14);
`endif
        set_write(4'd1, 19'h1234a, 8'd3, 1'b0, 25'h0000003, 25'h0000005);
        wr_random = 1'b1;
        do_cycle();
        idle();
`ifdef TLB_RANDOM_EN
        r_index = 4'd14;
`else
        r_index = 4'd1;
`endif
        r_req = 1'b1;
        do_cycle();
        check("t5_tlbwr", r_vpn2, 19'h1234a);
        idle();

        // Randomized traffic on a small VPN/ASID pool to force hits and aliases.
        for (int n = 0; n < 400; n++) begin
            cur_asid = 8'($urandom_range(0, 3));
            i_req = 1'($urandom); d_req = 1'($urandom);
            r_req = 1'($urandom); p_req = 1'($urandom);
            i_vpn = 20'($urandom_range(0, 15)); d_vpn = 20'($urandom_range(0, 15));
            p_vpn2 = 19'($urandom_range(0, 7)); p_asid = 8'($urandom_range(0, 3));
            r_index = 4'($urandom);
            we = ($urandom_range(0, 3) == 0); wr_random = 1'($urandom);
            w_index = 4'($urandom); w_vpn2 = 19'($urandom_range(0, 7));
            w_asid = 8'($urandom_range(0, 3)); w_g = ($urandom_range(0, 3) == 0);
            w_lo0 = 25'($urandom); w_lo1 = 25'($urandom);
            if ($urandom_range(0, 31) == 0) wired = 4'($urandom);
            do_cycle();
        end
        idle();

        // Asynchronous reset in the middle of active requests.
        set_write(4'd3, 19'h00200, 8'd5, 1'b1, 25'h0000001, 25'h0000003);
        do_cycle();
        idle();
        i_req = 1'b1; p_req = 1'b1; i_vpn = 20'h00401; p_vpn2 = 19'h00200;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check("rst_no_ivalid", i_valid, 1'b0);
        check("rst_no_pvalid", p_valid, 1'b0);
        idle();
        rst = 1'b1;
        i_req = 1'b1; i_vpn = 20'h00401;
        do_cycle();
        check("rst_entries_gone", i_hit, 1'b0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
